// File: rtl/lmu_pchinfo_feeder_if.sv
// Patch-info handshake bundle: upstream write channel and LMU head/pop channel.
interface lmu_pchinfo_feeder_if #(
  parameter int PCHTYPE_BW = 4,
  parameter int FACEBD_BW  = 2,
  parameter int OPCODE_BW  = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [PCHTYPE_BW-1:0] wr_pchtype;
  logic [FACEBD_BW-1:0]  wr_facebd_n;
  logic [OPCODE_BW-1:0]  wr_pchop0;
  logic [OPCODE_BW-1:0]  wr_pchop1;
  logic                  pchinfo_pop;
  logic                  pchinfo_valid;
  logic [PCHTYPE_BW-1:0] pchtype;
  logic [FACEBD_BW-1:0]  facebd_n;
  logic [OPCODE_BW-1:0]  pchop0;
  logic [OPCODE_BW-1:0]  pchop1;
  logic                  pchinfo_rdlast;

  modport master (
    output wr_valid, wr_pchtype, wr_facebd_n, wr_pchop0, wr_pchop1, pchinfo_pop,
    input  wr_ready, pchinfo_valid, pchtype, facebd_n, pchop0, pchop1, pchinfo_rdlast
  );

  modport slave (
    input  wr_valid, wr_pchtype, wr_facebd_n, wr_pchop0, wr_pchop1, pchinfo_pop,
    output wr_ready, pchinfo_valid, pchtype, facebd_n, pchop0, pchop1, pchinfo_rdlast
  );
endinterface

// File: rtl/lmu_pchinfo_feeder.sv
// Two-array patch-info buffer; only whole NUM_PCH-entry arrays are exposed to the LMU.
module lmu_pchinfo_feeder #(
  parameter int NUM_PCH    = 16,
  parameter int PCHTYPE_BW = 4,
  parameter int FACEBD_BW  = 2,
  parameter int OPCODE_BW  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lmu_pchinfo_feeder_if.slave  bus,
  input  logic                 flush,
  output logic [1:0]           arrays_avail,
  output logic                 err_underflow
);
  localparam int DEPTH = 2 * NUM_PCH;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(NUM_PCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PCH - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PCHTYPE_BW-1:0] pchtype;
    logic [FACEBD_BW-1:0]  facebd_n;
    logic [OPCODE_BW-1:0]  pchop0;
    logic [OPCODE_BW-1:0]  pchop1;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry, head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    avail_q, avail_d;
  logic          err_q, err_d;
  logic          head_vld, wr_fire, pop_fire, complete, retire;

  assign head_vld     = (avail_q != 2'd0);
  assign bus.wr_ready = (count_q < DEPTH_C);
  assign wr_fire      = bus.wr_valid & bus.wr_ready & ~flush;
  assign pop_fire     = bus.pchinfo_pop & head_vld & ~flush;
  assign complete     = wr_fire  & (wr_ptr_q[IW-1:0] == LAST_IDX);
  assign retire       = pop_fire & (rd_ptr_q[IW-1:0] == LAST_IDX);

  assign wr_entry = '{pchtype:  bus.wr_pchtype, facebd_n: bus.wr_facebd_n,
                      pchop0:   bus.wr_pchop0,  pchop1:   bus.wr_pchop1};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    avail_d  = avail_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      avail_d  = '0;
      err_d    = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally
      if (wr_fire)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      case ({complete, retire})
        2'b10:   avail_d = avail_q + 2'd1;
        2'b01:   avail_d = avail_q - 2'd1;
        default: avail_d = avail_q;
      endcase
      if (bus.pchinfo_pop & ~head_vld) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; the head is masked whenever no full array is held.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head               = mem_q[rd_ptr_q];
  assign bus.pchinfo_valid  = head_vld;
  assign bus.pchtype        = head_vld ? head.pchtype  : '0;
  assign bus.facebd_n       = head_vld ? head.facebd_n : '0;
  assign bus.pchop0         = head_vld ? head.pchop0   : '0;
  assign bus.pchop1         = head_vld ? head.pchop1   : '0;
  assign bus.pchinfo_rdlast = head_vld & (rd_ptr_q[IW-1:0] == LAST_IDX);
  assign arrays_avail       = avail_q;
  assign err_underflow      = err_q;
endmodule

// File: tb/tb_lmu_pchinfo_feeder.sv
// Scoreboard bench: accepted entries are queued, compared at the head each cycle and on pops.
module tb_lmu_pchinfo_feeder;
  localparam int N     = 16;
  localparam int DEPTH = 2 * N;

  typedef struct {
    logic [3:0] pt;
    logic [1:0] fb;
    logic [3:0] o0;
    logic [3:0] o1;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0] arrays_avail;
  logic err_underflow;

  lmu_pchinfo_feeder_if #(.PCHTYPE_BW(4), .FACEBD_BW(2), .OPCODE_BW(4)) bus ();

  lmu_pchinfo_feeder #(.NUM_PCH(N), .PCHTYPE_BW(4), .FACEBD_BW(2), .OPCODE_BW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .arrays_avail(arrays_avail), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  int   wcnt = 0;
  int   rcnt = 0;
  bit   err_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares outputs against the model, then advances the model for the coming edge.
  initial forever begin
    int   avail;
    bit   vld, full;
    ent_t e;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete(); wcnt = 0; rcnt = 0; err_m = 1'b0;
    end
    avail = wcnt / N - rcnt / N;
    vld   = (avail != 0);
    full  = (sb.size() == DEPTH);
    chk("wr_ready", bus.wr_ready, !full);
    chk("pchinfo_valid", bus.pchinfo_valid, vld);
    chk("arrays_avail", arrays_avail, avail);
    chk("err_underflow", err_underflow, err_m);
    chk("pchinfo_rdlast", bus.pchinfo_rdlast, vld && (rcnt % N == N - 1));
    if (vld) e = sb[0];
    else     e = '{pt: 4'd0, fb: 2'd0, o0: 4'd0, o1: 4'd0};
    chk("pchtype", bus.pchtype, e.pt);
    chk("facebd_n", bus.facebd_n, e.fb);
    chk("pchop0", bus.pchop0, e.o0);
    chk("pchop1", bus.pchop1, e.o1);
    if (rst_n) begin
      if (flush) begin
        sb.delete(); wcnt = 0; rcnt = 0; err_m = 1'b0;
      end else begin
        if (bus.pchinfo_pop && vld) begin
          void'(sb.pop_front());
          rcnt++;
        end
        if (bus.pchinfo_pop && !vld) err_m = 1'b1;
        if (bus.wr_valid && !full) begin
          sb.push_back('{pt: bus.wr_pchtype, fb: bus.wr_facebd_n,
                         o0: bus.wr_pchop0, o1: bus.wr_pchop1});
          wcnt++;
        end
      end
    end
  end

  // op0 < 0 selects a random opcode.
  task automatic step(input bit wv, input bit pop, input bit fl, input int op0);
    logic [31:0] r;
    r = $urandom;
    bus.wr_valid    = wv;
    bus.wr_pchtype  = r[3:0];
    bus.wr_facebd_n = r[5:4];
    bus.wr_pchop1   = r[11:8];
    if (op0 < 0) bus.wr_pchop0 = r[15:12];
    else         bus.wr_pchop0 = 4'(op0);
    bus.pchinfo_pop = pop;
    flush           = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic writes(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, (base < 0) ? -1 : base + i);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic rst_pulse();
    bus.wr_valid = 1'b0;
    bus.pchinfo_pop = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.wr_valid = 1'b1;
    bus.wr_pchtype = 4'h5; bus.wr_facebd_n = 2'h1;
    bus.wr_pchop0 = 4'h3; bus.wr_pchop1 = 4'h7;
    bus.pchinfo_pop = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single array
    writes(N, 1);
    step(1'b0, 1'b0, 1'b0, -1);
    pops(N);
    step(1'b0, 1'b0, 1'b0, -1);

    // fill beyond capacity, then drain both arrays
    writes(DEPTH + 1, -1);
    pops(1);
    step(1'b0, 1'b0, 1'b0, -1);
    pops(DEPTH - 1);
    step(1'b0, 1'b0, 1'b0, -1);

    // completion and retire on the same edge
    writes(N, -1);
    pops(N - 1);
    writes(N - 1, -1);
    step(1'b1, 1'b1, 1'b0, -1);
    pops(N + 2);

    // underflow stays sticky until flush
    step(1'b0, 1'b1, 1'b0, -1);
    writes(3, -1);
    step(1'b0, 1'b0, 1'b0, -1);
    step(1'b0, 1'b1, 1'b1, -1);
    step(1'b0, 1'b0, 1'b0, -1);

    // mid-array reset, then mid-array flush
    writes(10, -1);
    rst_pulse();
    writes(N, 1);
    pops(N);
    writes(10, -1);
    step(1'b1, 1'b1, 1'b1, -1);
    writes(N, 1);
    pops(N);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      step(r[1:0] != 2'd0, r[3:2] == 2'd0 || (r[4] && r[5]), r[15:8] == 8'd0, -1);
    end
    step(1'b0, 1'b0, 1'b0, -1);
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
